// File: rtl/dec_grant_pkg.sv
// Shared types and widths for the dec_grant grant decoder.
package dec_grant_pkg;

   localparam int unsigned CodeW = 2;
   localparam int unsigned OutW  = 4;
   localparam int unsigned CntW  = $clog2(256);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StGap   = 2'd2
   } state_e;

endpackage

// File: rtl/dec_grant_if.sv
// Code/grant bus between a request encoder (master) and dec_grant (slave).
interface dec_grant_if;
   import dec_grant_pkg::*;

   logic [CodeW-1:0] i;
   logic             valid;
   logic             ready;
   logic [OutW-1:0]  o;
   logic             busy;
   logic             err;

   modport master (output i, valid, input ready, o, busy, err);
   modport slave  (input i, valid, output ready, o, busy, err);

endinterface

// File: rtl/dec_2to4.sv
// Combinational 2-to-4 one-hot decoder.
module dec_2to4
   import dec_grant_pkg::*;
(
   input  logic [CodeW-1:0] code_i,
   output logic [OutW-1:0]  onehot_o
);

   always_comb begin
      onehot_o         = '0;
      onehot_o[code_i] = 1'b1;
   end

endmodule

// File: rtl/dec_grant.sv
// Registered 2-to-4 grant decoder: holds each one-hot grant, then forces a quiet gap.
// Build option DEC_GRANT_EXTEND_EN lets a repeated code extend an active grant.
module dec_grant
   import dec_grant_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input logic        clk,
   input logic        rst_n,
   dec_grant_if.slave bus
);

   localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] GapLoad  = (GAP_CYCLES > 0) ? CntW'(GAP_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic [CntW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [CntW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CodeW-1:0] code_q, code_d;
   logic [OutW-1:0]  o_q, o_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [OutW-1:0]  onehot;
   logic             ready;
   logic             accept;
   logic             reload;
   logic             conflict;

`ifdef DEC_GRANT_EXTEND_EN
   assign ready    = (state_q == StIdle) || (state_q == StGrant);
   assign reload   = accept && (state_q == StGrant) && (bus.i == code_q);
   assign conflict = accept && (state_q == StGrant) && (bus.i != code_q);
`else
   assign ready    = (state_q == StIdle);
   assign reload   = 1'b0;
   assign conflict = 1'b0;
`endif

   assign accept = bus.valid && ready;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      code_d     = code_q;
      err_d      = err_q | conflict;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               code_d     = bus.i;
               hold_cnt_d = HoldLoad;
               state_d    = StGrant;
            end
         end
         StGrant: begin
            if (reload) begin
               hold_cnt_d = HoldLoad;
            end else if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - CntW'(1);
            end else if (GAP_CYCLES > 0) begin
               gap_cnt_d = GapLoad;
               state_d   = StGap;
            end else begin
               state_d = StIdle;
            end
         end
         StGap: begin
            if (gap_cnt_q != '0) begin
               gap_cnt_d = gap_cnt_q - CntW'(1);
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Decode the next code so the grant appears one cycle after acceptance.
   dec_2to4 u_dec (
      .code_i   (code_d),
      .onehot_o (onehot)
   );

   always_comb begin
      o_d    = (state_d == StGrant) ? onehot : '0;
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         code_q     <= '0;
         o_q        <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         code_q     <= code_d;
         o_q        <= o_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign bus.ready = ready;
   assign bus.o     = o_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule
